uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Transmit-side byte buffer that sits directly upstream of the MiniUART. The CPU-side bridge pushes bytes into a FIFO. The block then drains them into the UART as a WISHBONE master: it polls the line status register until the transmitter is idle, then writes one byte to the data register. This lets software queue a burst of characters without busy-waiting on LSR.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- AW, 4: log2(DEPTH).
- OFF_DATA, 3'd0: UART data-register offset (ADD[4:2]); must equal the UART offset header value.
- OFF_LSR, 3'd4: UART line-status-register offset; must equal the UART offset header value.
- TS_BIT, 5: bit of LSR read data that carries the transmitter-idle flag.
- GUARD, 3: cycles to wait after a data write before the first LSR poll; range 2..15.

Ports:
- CLK_I  in  1  clock; everything is on the rising edge.
- RST_N_I  in  1  asynchronous, active-low reset.
- push_i  in  1  enqueue push_data_i this cycle.
- push_data_i  in  8  byte to enqueue.
- clr_ovf_i  in  1  clears overflow_o.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- count_o  out  AW+1  occupancy.
- overflow_o  out  1  sticky; set by a push while full.
- busy_o  out  1  state != IDLE or !empty_o.
- M_ADD_O  out  3  UART address [4:2].
- M_DAT_O  out  32  write data, {24'b0, byte}.
- M_DAT_I  in  32  UART read data.
- M_STB_O  out  1  strobe.
- M_WE_O  out  1  write enable.
- M_ACK_I  in  1  acknowledge; the UART returns it combinationally, same cycle as M_STB_O.

## Operation
- FIFO storage: DEPTH×8 register array with AW-bit write and read pointers.
  - Pointers wrap naturally modulo DEPTH.
  - Occupancy is kept in a separate AW+1-bit counter.
- Push:
  - Accepted when push_i=1 and full_o=0 at the clock edge.
  - A push while full is dropped and sets overflow_o. This holds even if a pop happens in the same cycle.
- Pop: happens only in WRITE when M_ACK_I=1.
  - Push and pop in the same cycle leave count unchanged; both pointers advance.
- overflow_o: set has priority over clr_ovf_i when both occur in the same cycle.
- FSM states are IDLE, POLL, WRITE and WAIT. The state register is the only source of master outputs. Outputs are decoded from state and the FIFO head, with no other combinational input paths.
  - IDLE: M_STB_O=0. Go to POLL if !empty_o.
  - POLL: M_STB_O=1, M_WE_O=0, M_ADD_O=OFF_LSR.
    - If M_ACK_I=1 and M_DAT_I[TS_BIT]=1, go to WRITE.
    - Otherwise stay; this re-polls every cycle.
  - WRITE: M_STB_O=1, M_WE_O=1, M_ADD_O=OFF_DATA, M_DAT_O={24'b0, fifo[rd_ptr]}.
    - If M_ACK_I=1: pop, load the wait counter with GUARD−1, go to WAIT.
    - Otherwise hold.
  - WAIT: M_STB_O=0. Decrement the counter; at 0 go to IDLE.
- WAIT exists because the UART latches the load one cycle after the write and deasserts ts later. Polling too early would see a stale ts=1 and overrun the transmitter.
- The data-register strobe is exactly one cycle per byte. The UART's load generation ignores a write in the cycle right after a load, so back-to-back writes are forbidden. WAIT guarantees this.
- When idle, M_ADD_O=OFF_LSR, M_DAT_O=0 and M_WE_O=0.

## Timing
- Reset (async assert, sync release):
  - State IDLE, pointers 0, count_o=0, empty_o=1, full_o=0, overflow_o=0, busy_o=0.
  - M_STB_O=0, M_WE_O=0, M_DAT_O=0, M_ADD_O=OFF_LSR.
- Reset mid-transfer aborts immediately and discards FIFO contents. No partial strobe follows.
- Push at edge t: count_o and empty_o update after t; busy_o=1 after t.
- Latency, empty FIFO with UART idle: push at edge t gives POLL in cycle t+1..t+2 and the WRITE strobe in cycle t+2..t+3.
- Steady-state throughput with ts always 1 is one byte per GUARD+3 cycles (POLL, WRITE, GUARD×WAIT, IDLE).
- Last byte popped: empty_o=1 after the WRITE edge; busy_o stays 1 until IDLE.

## Test plan
- Reset:
  - Stimulus: hold RST_N_I=0 with push_i=1.
  - Required: all outputs are at their reset values and count_o stays 0.
  - After release: one push of 8'h41 produces exactly one write with M_ADD_O=OFF_DATA and M_DAT_O=32'h41.
- Burst in order:
  - Stimulus: push 8'h30..8'h39 on consecutive cycles; UART model drives ts=1 constantly.
  - Required: 10 data writes in order, each separated by exactly GUARD+2 non-write cycles.
- Busy transmitter:
  - Stimulus: ts=0 for 50 cycles, then 1.
  - Required: POLL strobes every cycle, no write while ts=0, and the write lands in the cycle after the first ts=1 ACK.
- Full/overflow:
  - Stimulus: ts=0; push 17 bytes.
  - Required: full_o=1 and count_o=16 after 16 pushes; the 17th push sets overflow_o and count_o stays 16.
  - Then: clr_ovf_i clears the flag; with simultaneous set and clear, overflow_o stays 1.
- Pointer wrap:
  - Stimulus: 40 bytes with pushes interleaved with drains.
  - Required: output sequence matches the input sequence; count_o never exceeds 16 and never underflows.
- Push-during-pop: a push coinciding with a WRITE ACK leaves count_o unchanged.

Source files
------------

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Purpose  : Transmit byte FIFO feeding the MiniUART. Bytes pushed by the CPU
//            bridge are drained as a WISHBONE master: poll LSR until the
//            transmitter is idle, write one byte to the data register, then
//            hold off for a guard interval before polling again.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_buffer #(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter logic [2:0] OFF_DATA = 3'd0,
  parameter logic [2:0] OFF_LSR  = 3'd4,
  parameter int         TS_BIT   = 5,
  parameter int         GUARD    = 3
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          clr_ovf_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  output logic          busy_o,
  output logic [2:0]    M_ADD_O,
  output logic [31:0]   M_DAT_O,
  input  logic [31:0]   M_DAT_I,
  output logic          M_STB_O,
  output logic          M_WE_O,
  input  logic          M_ACK_I
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POLL  = 2'd1,
    S_WRITE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  localparam logic [AW:0]   CNT_FULL  = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  // WAIT lasts GUARD cycles: the counter runs GUARD-1 down to 0.
  localparam logic [3:0]    WAIT_LOAD = 4'(GUARD - 1);

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    wait_q, wait_d;
  logic          push_ok;
  logic          pop;
  logic          ts;
  logic [31:0]   dat_unused;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q != S_IDLE) || !empty_o;

  assign push_ok    = push_i && !full_o;
  assign ts         = M_DAT_I[TS_BIT];
  // Only the transmitter-idle flag of the LSR read data matters here.
  assign dat_unused = M_DAT_I & ~(32'd1 << TS_BIT);

  // Occupancy and sticky overflow; a push while full sets overflow even if a
  // pop frees a slot on the same edge, and set wins over clear.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end
    ovf_d = ovf_q;
    if (push_i && full_o) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Master FSM next state and bus outputs, decoded from state and FIFO head only.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    M_STB_O = 1'b0;
    M_WE_O  = 1'b0;
    M_ADD_O = OFF_LSR;
    M_DAT_O = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty_o) begin
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        M_STB_O = 1'b1;
        if (M_ACK_I && ts) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        M_STB_O = 1'b1;
        M_WE_O  = 1'b1;
        M_ADD_O = OFF_DATA;
        M_DAT_O = {24'b0, mem_q[rd_ptr_q]};
        if (M_ACK_I) begin
          pop     = 1'b1;
          wait_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Keeps the UART from being polled before its ts flag drops.
        if (wait_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge CLK_I) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Control state: pointers, occupancy, overflow flag, FSM and guard counter.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      wait_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Purpose  : Self-checking bench for uart_tx_buffer. A behavioural model
//            (byte queue plus bus-phase bookkeeping) is compared against the
//            DUT every cycle; directed sequences pin literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffer;

  localparam int         DEPTH    = 16;
  localparam int         AW       = 4;
  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_LSR  = 3'd4;
  localparam int         TS_BIT   = 5;
  localparam int         GUARD    = 3;

  logic          CLK_I = 1'b0;
  logic          RST_N_I = 1'b0;
  logic          push_i = 1'b0;
  logic [7:0]    push_data_i = 8'h00;
  logic          clr_ovf_i = 1'b0;
  logic          full_o, empty_o, overflow_o, busy_o;
  logic [AW:0]   count_o;
  logic [2:0]    M_ADD_O;
  logic [31:0]   M_DAT_O;
  logic [31:0]   M_DAT_I;
  logic          M_STB_O, M_WE_O, M_ACK_I;

  logic          ts = 1'b1;
  logic [31:0]   noise = 32'h0;

  uart_tx_buffer #(
    .DEPTH(DEPTH), .AW(AW), .OFF_DATA(OFF_DATA), .OFF_LSR(OFF_LSR),
    .TS_BIT(TS_BIT), .GUARD(GUARD)
  ) dut (
    .CLK_I(CLK_I), .RST_N_I(RST_N_I),
    .push_i(push_i), .push_data_i(push_data_i), .clr_ovf_i(clr_ovf_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .busy_o(busy_o),
    .M_ADD_O(M_ADD_O), .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I),
    .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ACK_I(M_ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  // UART slave: combinational ack, LSR read data carries ts at TS_BIT.
  assign M_ACK_I = M_STB_O;
  always_comb begin
    M_DAT_I         = noise;
    M_DAT_I[TS_BIT] = ts;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];        // bytes waiting in the buffer
  bit         movf = 0;
  int         sil = 0;      // remaining bus-silent cycles after a write
  bit         eng = 0;      // engine is strobing the bus (poll or write)
  bit         wdue = 0;     // previous poll saw the transmitter idle
  int         cyc = 0;
  int         dpolls = 0;
  int         ts_mark = -1;
  logic [7:0] wlog[$];
  int         wcyc[$];
  logic [2:0] wadd[$];
  bit         m_ne, m_full, m_pop, m_busy;

  task automatic check_quiet(input string tag);
    check({tag, "_stb"}, M_STB_O, 0);
    check({tag, "_we"},  M_WE_O,  0);
    check({tag, "_add"}, M_ADD_O, OFF_LSR);
    check({tag, "_dat"}, M_DAT_O, 0);
  endtask

  // Compare DUT against the model every cycle, then advance the model with this cycle's inputs.
  always @(negedge CLK_I) begin
    cyc++;
    if (M_STB_O && !M_WE_O) dpolls++;
    if (!RST_N_I) begin
      mq.delete(); movf = 0; sil = 0; eng = 0; wdue = 0;
      check("rst_count", count_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_ovf", overflow_o, 0);
      check("rst_busy", busy_o, 0);
      check_quiet("rst");
    end else begin
      m_ne   = (mq.size() != 0);
      m_full = (mq.size() == DEPTH);
      m_pop  = 0;
      check("count", count_o, mq.size());
      check("empty", empty_o, !m_ne);
      check("full", full_o, m_full);
      check("ovf", overflow_o, movf);
      if (sil > 0) begin
        check_quiet("guard");
        m_busy = (sil > 1) ? 1'b1 : m_ne;
        if (sil == 1) eng = m_ne;
        sil--;
      end else if (!eng) begin
        check_quiet("idle");
        m_busy = m_ne;
        eng = m_ne;
      end else begin
        m_busy = 1'b1;
        check("strobe", M_STB_O, 1);
        if (wdue) begin
          check("wr_we", M_WE_O, 1);
          check("wr_add", M_ADD_O, OFF_DATA);
          check("wr_dat", M_DAT_O, {24'b0, mq[0]});
          check("wr_nonempty", m_ne, 1);
          wlog.push_back(M_DAT_O[7:0]);
          wcyc.push_back(cyc);
          wadd.push_back(M_ADD_O);
          m_pop = m_ne; wdue = 0; eng = 0; sil = GUARD + 1;
        end else begin
          check("poll_we", M_WE_O, 0);
          check("poll_add", M_ADD_O, OFF_LSR);
          if (ts) begin
            wdue = 1;
            if (ts_mark < 0) ts_mark = cyc;
          end
        end
      end
      check("busy", busy_o, m_busy);
      if (push_i && m_full) movf = 1;
      else if (clr_ovf_i) movf = 0;
      if (m_pop) void'(mq.pop_front());
      if (push_i && !m_full) mq.push_back(push_data_i);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK_I);
    #1;
    noise = $urandom;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_i = 1'b1;
    push_data_i = b;
    tick();
    push_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    check("idle_timeout", (n < 1000), 1);
  endtask

  logic [7:0] sent[$];
  logic [7:0] b;
  int         n, k, wsz;

  initial begin
    // Reset held with push asserted: nothing may enter.
    RST_N_I = 1'b0; push_i = 1'b1; push_data_i = 8'h55; ts = 1'b1;
    repeat (4) tick();
    @(negedge CLK_I);
    check("rst_hold_count", count_o, 0);
    check("rst_hold_add", M_ADD_O, OFF_LSR);
    tick();
    RST_N_I = 1'b1; push_i = 1'b0;
    push_byte(8'h41);
    repeat (20) tick();
    check("first_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("first_data", wlog[0], 8'h41);
      check("first_add", wadd[0], OFF_DATA);
    end

    // Burst with transmitter always idle: order and spacing.
    wait_idle();
    wlog.delete(); wcyc.delete(); wadd.delete();
    for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i));
    wait_idle();
    check("burst_nwrites", wlog.size(), 10);
    if (wlog.size() == 10) begin
      for (int i = 0; i < 10; i++) check("burst_data", wlog[i], 8'h30 + 8'(i));
      for (int i = 1; i < 10; i++) check("burst_gap", wcyc[i] - wcyc[i-1], GUARD + 3);
    end

    // Busy transmitter: polls every cycle, write right after first ts=1 ack.
    wlog.delete(); wcyc.delete();
    ts = 1'b0;
    push_byte(8'h77);
    dpolls = 0;
    repeat (50) tick();
    check("busy_nowrite", wlog.size(), 0);
    check("busy_polls", (dpolls >= 48), 1);
    ts_mark = -1;
    ts = 1'b1;
    repeat (10) tick();
    check("busy_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("busy_data", wlog[0], 8'h77);
      check("busy_latency", wcyc[0], ts_mark + 1);
    end

    // Fill to full, overflow, clear, set-beats-clear, then drain.
    wait_idle();
    ts = 1'b0;
    wlog.delete(); sent.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      push_byte(b);
    end
    @(negedge CLK_I);
    check("full_count", count_o, 16);
    check("full_flag", full_o, 1);
    check("full_noovf", overflow_o, 0);
    tick();
    push_byte(8'hEE);
    @(negedge CLK_I);
    check("ovf_set", overflow_o, 1);
    check("ovf_count", count_o, 16);
    tick();
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    @(negedge CLK_I);
    check("ovf_clr", overflow_o, 0);
    tick();
    clr_ovf_i = 1'b1; push_i = 1'b1; push_data_i = 8'hDD;
    tick();
    clr_ovf_i = 1'b0; push_i = 1'b0;
    @(negedge CLK_I);
    check("ovf_set_wins", overflow_o, 1);
    check("ovf_count2", count_o, 16);
    tick();
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0; ts = 1'b1;
    wait_idle();
    check("full_nwrites", wlog.size(), 16);
    if (wlog.size() == 16)
      for (int i = 0; i < 16; i++) check("full_order", wlog[i], sent[i]);

    // Pointer wrap: random pushes interleaved with drains, random ts.
    wlog.delete(); sent.delete();
    n = 0; k = 0;
    while (n < 40 && k < 5000) begin
      ts = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0 && count_o < 5'd16) begin
        push_i = 1'b1;
        push_data_i = 8'($urandom);
        sent.push_back(push_data_i);
        n++;
      end else begin
        push_i = 1'b0;
      end
      tick();
      k++;
    end
    push_i = 1'b0; ts = 1'b1;
    wait_idle();
    check("wrap_nwrites", wlog.size(), 40);
    if (wlog.size() == 40)
      for (int i = 0; i < 40; i++) check("wrap_order", wlog[i], sent[i]);

    // Push coinciding with a write ack leaves count unchanged.
    wlog.delete();
    push_byte(8'h11);
    k = 0;
    while (!(M_STB_O && !M_WE_O) && k < 20) begin
      @(negedge CLK_I);
      k++;
    end
    check("pp_poll_seen", (k < 20), 1);
    tick();
    push_i = 1'b1; push_data_i = 8'h22;
    @(negedge CLK_I);
    check("pp_in_write", M_WE_O, 1);
    check("pp_count_before", count_o, 1);
    tick();
    push_i = 1'b0;
    @(negedge CLK_I);
    check("pp_count_after", count_o, 1);
    tick();
    wait_idle();
    check("pp_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("pp_data0", wlog[0], 8'h11);
      check("pp_data1", wlog[1], 8'h22);
    end

    // Reset during a write strobe aborts and discards the FIFO.
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    k = 0;
    while (!(M_STB_O && M_WE_O) && k < 30) begin
      @(negedge CLK_I);
      k++;
    end
    check("mid_write_seen", (k < 30), 1);
    #1;
    RST_N_I = 1'b0;
    #1;
    check("mid_abort_stb", M_STB_O, 0);
    check("mid_abort_count", count_o, 0);
    wsz = wlog.size();
    repeat (3) tick();
    RST_N_I = 1'b1;
    repeat (30) tick();
    check("mid_no_more_writes", wlog.size(), wsz);
    check("mid_empty", empty_o, 1);
    check("mid_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
